// File: rtl/playfield_mixer.sv
// Merges sprite draw flags into registered VGA colour, drives the shared 'empty'
// neighbour signal, latches per-frame collisions, keeps a saturating score and the move tick.
module playfield_mixer #(
  parameter int N_AST    = 4,
  parameter int BORDER   = 2,
  parameter int MOVE_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pixpulse,
  input  logic [9:0]       hcount,
  input  logic [9:0]       vcount,
  input  logic             draw_ship,
  input  logic             draw_bullet,
  input  logic [N_AST-1:0] draw_ast,
  output logic             empty,
  output logic             move,
  output logic [11:0]      rgb,
  output logic [N_AST-1:0] ast_hit,
  output logic             ship_hit,
  output logic             frame_done,
  output logic [15:0]      score
);

  localparam logic [3:0] DIV_LAST = 4'(MOVE_DIV - 1);

  logic             vis;
  logic             wall;
  logic             any_ast;
  logic             fe;
  logic [N_AST-1:0] pend_ast;
  logic             pend_ship;
  logic [3:0]       div;
  logic [11:0]      rgb_next;
  logic [16:0]      hit_sum;

  assign vis     = (hcount < 10'd640) && (vcount < 10'd480);
  assign wall    = vis && ((hcount < 10'(BORDER)) || (hcount >= 10'(640 - BORDER)) ||
                           (vcount < 10'(BORDER)) || (vcount >= 10'(480 - BORDER)));
  assign any_ast = |draw_ast;
  // Sprites outside the visible area never block a neighbour scan.
  assign empty   = ~(vis & (wall | draw_ship | draw_bullet | any_ast));
  assign fe      = pixpulse && (hcount == 10'd0) && (vcount == 10'd480);

  always_comb begin
    rgb_next = 12'h000;
    if (vis) begin
      if (draw_ship)        rgb_next = 12'hFFF;
      else if (draw_bullet) rgb_next = 12'hFF0;
      else if (any_ast)     rgb_next = 12'hA52;
      else if (wall)        rgb_next = 12'h00F;
    end
  end

  // One extra bit so a wrap past 16'hFFFF is visible for saturation.
  always_comb begin
    hit_sum = {1'b0, score};
    for (int i = 0; i < N_AST; i++) hit_sum = hit_sum + 17'(pend_ast[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb        <= 12'h000;
      move       <= 1'b0;
      ast_hit    <= '0;
      ship_hit   <= 1'b0;
      frame_done <= 1'b0;
      score      <= 16'h0000;
      pend_ast   <= '0;
      pend_ship  <= 1'b0;
      div        <= 4'd0;
    end else begin
      frame_done <= fe;
      if (pixpulse) begin
        rgb  <= rgb_next;
        move <= 1'b0;
        if (fe) begin
          ast_hit   <= pend_ast;
          ship_hit  <= pend_ship;
          pend_ast  <= '0;
          pend_ship <= 1'b0;
          score     <= hit_sum[16] ? 16'hFFFF : hit_sum[15:0];
          if (div == DIV_LAST) begin
            div  <= 4'd0;
            move <= 1'b1;
          end else begin
            div <= div + 4'd1;
          end
        end else if (vis) begin
          pend_ast  <= pend_ast | ({N_AST{draw_bullet}} & draw_ast);
          pend_ship <= pend_ship | (draw_ship & any_ast);
        end
      end
    end
  end

endmodule

// File: tb/tb_playfield_mixer.sv
// Randomized and directed bench for playfield_mixer; a frame-level model predicts
// every registered output, one negedge process compares both DUT instances.
module tb_playfield_mixer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pixpulse = 1'b0;
  logic [9:0]  hcount = '0;
  logic [9:0]  vcount = '0;
  logic        draw_ship = 1'b0;
  logic        draw_bullet = 1'b0;
  logic [3:0]  draw_ast = '0;

  logic        empty, move, ship_hit, frame_done;
  logic [11:0] rgb;
  logic [3:0]  ast_hit;
  logic [15:0] score;
  logic        empty3, move3, ship_hit3, frame_done3;
  logic [11:0] rgb3;
  logic [3:0]  ast_hit3;
  logic [15:0] score3;

  playfield_mixer #(.N_AST(4), .BORDER(2), .MOVE_DIV(1)) dut (
    .clk(clk), .rst(rst), .pixpulse(pixpulse), .hcount(hcount), .vcount(vcount),
    .draw_ship(draw_ship), .draw_bullet(draw_bullet), .draw_ast(draw_ast),
    .empty(empty), .move(move), .rgb(rgb), .ast_hit(ast_hit), .ship_hit(ship_hit),
    .frame_done(frame_done), .score(score));

  playfield_mixer #(.N_AST(4), .BORDER(2), .MOVE_DIV(3)) dut3 (
    .clk(clk), .rst(rst), .pixpulse(pixpulse), .hcount(hcount), .vcount(vcount),
    .draw_ship(draw_ship), .draw_bullet(draw_bullet), .draw_ast(draw_ast),
    .empty(empty3), .move(move3), .rgb(rgb3), .ast_hit(ast_hit3), .ship_hit(ship_hit3),
    .frame_done(frame_done3), .score(score3));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // model state
  logic [11:0] exp_rgb;
  logic [3:0]  exp_ast_hit, pend_m;
  logic        exp_ship_hit, exp_frame_done, exp_move, exp_move3, pend_ship_m;
  int          exp_score;
  int          frames;

  bit          cnt_move3_en = 1'b0;
  int          move3_clks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    exp_rgb = 0; exp_ast_hit = 0; pend_m = 0; exp_ship_hit = 0; exp_frame_done = 0;
    exp_move = 0; exp_move3 = 0; pend_ship_m = 0; exp_score = 0; frames = 0;
  endtask

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("rgb", rgb, exp_rgb);
      check("move", move, exp_move);
      check("ast_hit", ast_hit, exp_ast_hit);
      check("ship_hit", ship_hit, exp_ship_hit);
      check("frame_done", frame_done, exp_frame_done);
      check("score", score, exp_score);
      check("rgb3", rgb3, exp_rgb);
      check("move3", move3, exp_move3);
      check("ast_hit3", ast_hit3, exp_ast_hit);
      check("score3", score3, exp_score);
      check("frame_done3", frame_done3, exp_frame_done);
    end
    if (cnt_move3_en && move3) move3_clks++;
  end

  // One pixpulse cycle at (h,v); returns #1 after the active edge with the model updated.
  task automatic pix(input int h, input int v, input bit ship, input bit bullet,
                     input logic [3:0] ast);
    bit vis, wall, fe;
    int nhits;
    @(negedge clk);
    hcount = h[9:0]; vcount = v[9:0];
    draw_ship = ship; draw_bullet = bullet; draw_ast = ast; pixpulse = 1'b1;
    vis  = (h < 640) && (v < 480);
    wall = vis && (h < 2 || h >= 638 || v < 2 || v >= 478);
    #1;
    check("empty", empty, !(vis && (wall || ship || bullet || ast != 0)));
    @(posedge clk);
    #1;
    if (!vis)           exp_rgb = 12'h000;
    else if (ship)      exp_rgb = 12'hFFF;
    else if (bullet)    exp_rgb = 12'hFF0;
    else if (ast != 0)  exp_rgb = 12'hA52;
    else if (wall)      exp_rgb = 12'h00F;
    else                exp_rgb = 12'h000;
    fe = (h == 0) && (v == 480);
    exp_frame_done = fe;
    exp_move = 0;
    exp_move3 = 0;
    if (fe) begin
      frames++;
      exp_ast_hit  = pend_m;
      exp_ship_hit = pend_ship_m;
      nhits = 0;
      for (int i = 0; i < 4; i++) nhits += pend_m[i];
      exp_score = (exp_score + nhits > 65535) ? 65535 : exp_score + nhits;
      pend_m = 0;
      pend_ship_m = 0;
      exp_move  = 1'b1;
      exp_move3 = (frames % 3) == 0;
    end else if (vis) begin
      if (bullet) pend_m = pend_m | ast;
      if (ship && ast != 0) pend_ship_m = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      pixpulse = 1'b0;
      @(posedge clk);
      #1;
      exp_frame_done = 1'b0;
    end
  endtask

  task automatic pixg(input int h, input int v, input bit ship, input bit bullet,
                      input logic [3:0] ast);
    pix(h, v, ship, bullet, ast);
    idle(3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pixpulse = 1'b0;
    #1;
    check("rst_rgb", rgb, 0);
    check("rst_move", move, 0);
    check("rst_ast_hit", ast_hit, 0);
    check("rst_ship_hit", ship_hit, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_score", score, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int h, v;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    idle(2);

    // reset mid-line with a pending asteroid hit
    pixg(50, 60, 0, 1, 4'b0010);
    pixg(51, 60, 0, 0, 4'b0000);
    do_reset();
    pix(0, 480, 0, 0, 0);
    check("fe_after_rst_ast_hit", ast_hit, 0);
    check("fe_after_rst_score", score, 0);
    idle(3);

    // colour and empty at specific pixels
    pix(100, 100, 0, 0, 4'b0001);
    check("lit_empty_ast", empty, 0);
    check("lit_rgb_ast", rgb, 12'hA52);
    idle(3);
    pix(1, 200, 0, 0, 0);
    check("lit_empty_wall", empty, 0);
    check("lit_rgb_wall", rgb, 12'h00F);
    idle(3);
    pix(320, 240, 0, 0, 0);
    check("lit_empty_bg", empty, 1);
    check("lit_rgb_bg", rgb, 12'h000);
    idle(3);

    // bullet hit on asteroid 2, overlapping asteroids alone don't count
    pixg(50, 60, 0, 1, 4'b0100);
    pixg(70, 70, 0, 0, 4'b0011);
    pix(0, 480, 0, 0, 0);
    check("lit_ast_hit_0100", ast_hit, 4'b0100);
    check("lit_score_1", score, 1);
    check("lit_frame_done_hi", frame_done, 1);
    idle(1);
    check("lit_frame_done_lo", frame_done, 0);
    idle(2);
    pixg(320, 240, 0, 0, 0);
    pix(0, 480, 0, 0, 0);
    check("lit_quiet_ast_hit", ast_hit, 0);
    check("lit_quiet_score", score, 1);
    idle(3);

    // ship collision at the corner, lone bullet
    pix(639, 0, 1, 0, 4'b1000);
    check("lit_rgb_ship", rgb, 12'hFFF);
    idle(3);
    pixg(10, 10, 0, 1, 0);
    pix(0, 480, 0, 0, 0);
    check("lit_ship_hit", ship_hit, 1);
    check("lit_ship_ast_hit", ast_hit, 0);
    idle(3);

    // random frames
    for (int f = 0; f < 30; f++) begin
      for (int p = 0; p < 20; p++) begin
        case ($urandom_range(0, 3))
          0: begin h = $urandom_range(0, 1023); v = $urandom_range(0, 1023); end
          1: begin h = $urandom_range(0, 4); v = $urandom_range(0, 479); end
          2: begin h = $urandom_range(634, 645); v = $urandom_range(474, 485); end
          default: begin h = $urandom_range(0, 639); v = $urandom_range(0, 479); end
        endcase
        if (h < 640 && v < 480)
          pixg(h, v, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
               4'($urandom & $urandom));
        else
          pixg(h, v, 0, 0, 0);
      end
      pixg(0, 480, 0, 0, 0);
    end

    // move divider of 3: ticks on frames 3 and 6 only, one pixpulse period each
    do_reset();
    cnt_move3_en = 1'b1;
    for (int f = 1; f <= 7; f++) begin
      pixg(320, 240, 0, 0, 0);
      pix(0, 480, 0, 0, 0);
      check("lit_move3_frame", move3, (f == 3 || f == 6));
      idle(3);
    end
    pixg(320, 240, 0, 0, 0);
    cnt_move3_en = 1'b0;
    check("lit_move3_clks", move3_clks, 8);

    // score saturation, pixpulse every clk to keep the run short
    do_reset();
    for (int k = 0; k < 16383; k++) begin
      pix(50, 60, 0, 1, 4'hF);
      pix(0, 480, 0, 0, 0);
    end
    pix(50, 60, 0, 1, 4'b0011);
    pix(0, 480, 0, 0, 0);
    check("lit_score_fffe", score, 16'hFFFE);
    pix(50, 60, 0, 1, 4'b0111);
    pix(0, 480, 0, 0, 0);
    check("lit_score_sat", score, 16'hFFFF);
    pix(50, 60, 0, 1, 4'hF);
    pix(0, 480, 0, 0, 0);
    check("lit_score_hold", score, 16'hFFFF);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
